// File: rtl/ttt_game_ctrl.sv
// ttt_game_ctrl: turn sequencer and win/draw referee for the two-player O/X game
module ttt_game_ctrl #(
  parameter logic FIRST_PLAYER       = 1'b0,
  parameter int   AUTO_RESTART_TICKS = 30000,
  parameter int   CNT_W              = 15
) (
  input  logic       clk_10000Hz,
  input  logic       reset,
  input  logic       new_game,
  input  logic       move_valid,
  input  logic [3:0] move_cell,
  output logic       whosTurn,
  output logic [1:0] gameend,
  output logic [8:0] board_o,
  output logic [8:0] board_x,
  output logic [8:0] win_mask,
  output logic       move_ack,
  output logic       move_rej
);
  typedef enum logic [1:0] {PLAY, CHECK, DONE} state_t;
  localparam logic [71:0] LINES = {9'h007, 9'h038, 9'h1C0, 9'h049, 9'h092, 9'h124, 9'h111, 9'h054};
  state_t state, state_n;
  logic [8:0] board_o_n, board_x_n, win_mask_n, mover, hit;
  logic [1:0] gameend_n;
  logic whos_n, ack_n, rej_n, legal, restart;
  logic [3:0] moves, moves_n;
  logic [CNT_W-1:0] hold, hold_n;
  logic [15:0] occ;
  always_comb begin
    occ = {7'b0, board_o | board_x};
    legal = move_cell <= 4'd8 && !occ[move_cell];
    mover = whosTurn ? board_x : board_o;
    hit = '0;
    for (int i = 0; i < 8; i++)
      hit = hit | (((mover & LINES[9*i +: 9]) == LINES[9*i +: 9]) ? LINES[9*i +: 9] : 9'h0);
    restart = new_game || (state == DONE && AUTO_RESTART_TICKS != 0 && hold == CNT_W'(AUTO_RESTART_TICKS - 1));
    state_n = state;
    board_o_n = board_o;
    board_x_n = board_x;
    win_mask_n = win_mask;
    gameend_n = gameend;
    whos_n = whosTurn;
    moves_n = moves;
    hold_n = '0;
    ack_n = 1'b0;
    rej_n = 1'b0;
    if (restart) begin
      state_n = PLAY;
      board_o_n = '0;
      board_x_n = '0;
      win_mask_n = '0;
      gameend_n = 2'b00;
      whos_n = FIRST_PLAYER;
      moves_n = '0;
    end else if (state == PLAY) begin
      if (move_valid && legal) begin
        board_o_n = whosTurn ? board_o : board_o | (9'b1 << move_cell);
        board_x_n = whosTurn ? board_x | (9'b1 << move_cell) : board_x;
        moves_n = moves + 4'd1;
        ack_n = 1'b1;
        state_n = CHECK;
      end
      rej_n = move_valid && !legal;
    end else if (state == CHECK) begin
      rej_n = move_valid;
      if (|hit) begin
        gameend_n = whosTurn ? 2'b10 : 2'b01;
        win_mask_n = hit;
        state_n = DONE;
      end else if (moves == 4'd9) begin
        gameend_n = 2'b11;
        win_mask_n = '0;
        state_n = DONE;
      end else begin
        whos_n = ~whosTurn;
        state_n = PLAY;
      end
    end else begin
      rej_n = move_valid;
      hold_n = (AUTO_RESTART_TICKS != 0) ? hold + 1'b1 : '0;
    end
  end
  always_ff @(posedge clk_10000Hz) begin
    if (reset) begin
      state <= PLAY;
      board_o <= '0;
      board_x <= '0;
      win_mask <= '0;
      gameend <= 2'b00;
      whosTurn <= FIRST_PLAYER;
      moves <= '0;
      hold <= '0;
      move_ack <= 1'b0;
      move_rej <= 1'b0;
    end else begin
      state <= state_n;
      board_o <= board_o_n;
      board_x <= board_x_n;
      win_mask <= win_mask_n;
      gameend <= gameend_n;
      whosTurn <= whos_n;
      moves <= moves_n;
      hold <= hold_n;
      move_ack <= ack_n;
      move_rej <= rej_n;
    end
  end
endmodule

// File: tb/tb_ttt_game_ctrl.sv
// tb_ttt_game_ctrl: directed game scenarios checked against a cell-array game model
`timescale 1ns/1ps
module tb_ttt_game_ctrl;
  localparam int T = 5;
  logic clk_10000Hz = 1'b0, reset = 1'b1, new_game = 1'b0, move_valid = 1'b0;
  logic [3:0] move_cell = 4'd0;
  logic whosTurn, move_ack, move_rej;
  logic [1:0] gameend;
  logic [8:0] board_o, board_x, win_mask;
  int checks = 0, errors = 0, ack_cnt = 0, rej_cnt = 0, run = 0, last_run = 0;
  bit armed = 1'b0;
  int m_cell[9];
  int m_moves, m_phase, m_hold;
  logic m_turn, m_ack, m_rej;
  logic [1:0] m_end;
  logic [8:0] m_win;

  ttt_game_ctrl #(.FIRST_PLAYER(1'b0), .AUTO_RESTART_TICKS(T), .CNT_W(4)) dut (
    .clk_10000Hz(clk_10000Hz), .reset(reset), .new_game(new_game), .move_valid(move_valid),
    .move_cell(move_cell), .whosTurn(whosTurn), .gameend(gameend), .board_o(board_o),
    .board_x(board_x), .win_mask(win_mask), .move_ack(move_ack), .move_rej(move_rej));

  always #5 clk_10000Hz = ~clk_10000Hz;

  function automatic logic [8:0] bmap(int who);
    logic [8:0] b = '0;
    for (int i = 0; i < 9; i++) b[i] = (m_cell[i] == who);
    return b;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 9; i++) m_cell[i] = 0;
    m_moves = 0; m_phase = 0; m_hold = 0; m_turn = 1'b0;
    m_ack = 1'b0; m_rej = 1'b0; m_end = 2'b00; m_win = '0;
  endtask

  task automatic m_step();
    int p;
    logic [8:0] w;
    if (reset || new_game || (m_phase == 2 && m_hold == T - 1)) begin
      m_clear();
      return;
    end
    m_ack = 1'b0; m_rej = 1'b0;
    if (m_phase == 0) begin
      if (move_valid) begin
        if (move_cell < 9 && m_cell[move_cell] == 0) begin
          m_cell[move_cell] = m_turn ? 2 : 1;
          m_moves++; m_ack = 1'b1; m_phase = 1;
        end else m_rej = 1'b1;
      end
    end else if (m_phase == 1) begin
      m_rej = move_valid;
      p = m_turn ? 2 : 1;
      w = '0;
      for (int k = 0; k < 3; k++) begin
        if (m_cell[3*k] == p && m_cell[3*k+1] == p && m_cell[3*k+2] == p) w |= 9'b000000111 << (3*k);
        if (m_cell[k] == p && m_cell[k+3] == p && m_cell[k+6] == p) w |= 9'b001001001 << k;
      end
      if (m_cell[0] == p && m_cell[4] == p && m_cell[8] == p) w |= 9'b100010001;
      if (m_cell[2] == p && m_cell[4] == p && m_cell[6] == p) w |= 9'b001010100;
      if (w != 0) begin m_end = m_turn ? 2'b10 : 2'b01; m_win = w; m_phase = 2; m_hold = 0; end
      else if (m_moves == 9) begin m_end = 2'b11; m_win = '0; m_phase = 2; m_hold = 0; end
      else begin m_turn = ~m_turn; m_phase = 0; end
    end else begin
      m_rej = move_valid;
      m_hold++;
    end
  endtask

  task automatic chk(string name, logic [8:0] act, logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk_10000Hz);
    m_step();
  end

  initial forever begin
    @(negedge clk_10000Hz);
    if (armed) begin
      chk("whosTurn", 9'(whosTurn), 9'(m_turn));
      chk("gameend", 9'(gameend), 9'(m_end));
      chk("board_o", board_o, bmap(1));
      chk("board_x", board_x, bmap(2));
      chk("win_mask", win_mask, m_win);
      chk("move_ack", 9'(move_ack), 9'(m_ack));
      chk("move_rej", 9'(move_rej), 9'(m_rej));
      if (move_ack === 1'b1) ack_cnt++;
      if (move_rej === 1'b1) rej_cnt++;
      if (gameend != 2'b00) run++;
      else begin
        if (run != 0) last_run = run;
        run = 0;
      end
    end
  end

  task automatic move(input logic [3:0] c);
    move_cell = c; move_valid = 1'b1;
    @(negedge clk_10000Hz);
    move_valid = 1'b0;
    repeat (2) @(negedge clk_10000Hz);
  endtask

  task automatic restart_game();
    new_game = 1'b1;
    @(negedge clk_10000Hz);
    new_game = 1'b0;
    @(negedge clk_10000Hz);
  endtask

  task automatic chk_idle(string name);
    chk({name, "_gameend"}, 9'(gameend), 9'h0);
    chk({name, "_board_o"}, board_o, 9'h0);
    chk({name, "_board_x"}, board_x, 9'h0);
    chk({name, "_win_mask"}, win_mask, 9'h0);
    chk({name, "_whosTurn"}, 9'(whosTurn), 9'h0);
  endtask

  initial begin
    int a0, r0;
    m_clear();
    @(negedge clk_10000Hz);
    armed = 1'b1;
    @(negedge clk_10000Hz);
    reset = 1'b0;
    chk_idle("reset");
    // O completes the top row
    a0 = ack_cnt;
    move(0); move(3); move(1); move(4); move(2);
    chk("s1_acks", 9'(ack_cnt - a0), 9'd5);
    chk("s1_gameend", 9'(gameend), 9'h1);
    chk("s1_win_mask", win_mask, 9'h007);
    chk("s1_board_o", board_o, 9'h007);
    chk("s1_board_x", board_x, 9'h018);
    chk("s1_whosTurn", 9'(whosTurn), 9'h0);
    // move during DONE, then the automatic restart
    a0 = ack_cnt; r0 = rej_cnt;
    move_cell = 4'd5; move_valid = 1'b1;
    @(negedge clk_10000Hz);
    move_valid = 1'b0;
    chk("s4_rej", 9'(rej_cnt - r0), 9'd1);
    chk("s4_ack", 9'(ack_cnt - a0), 9'd0);
    for (int i = 0; i < 20 && gameend != 2'b00; i++) @(negedge clk_10000Hz);
    chk("s4_restart_timeout", 9'(gameend), 9'h0);
    @(negedge clk_10000Hz);
    chk("s4_done_len", 9'(last_run), 9'd5);
    chk_idle("s4");
    // illegal moves: occupied cell and out-of-range cell
    move(4);
    r0 = rej_cnt;
    move(4); move(9);
    chk("s2_rejs", 9'(rej_cnt - r0), 9'd2);
    chk("s2_board_x", board_x, 9'h0);
    chk("s2_whosTurn", 9'(whosTurn), 9'h1);
    chk("s2_gameend", 9'(gameend), 9'h0);
    restart_game();
    // new_game beats a simultaneous move
    move(0); move(1);
    a0 = ack_cnt; r0 = rej_cnt;
    new_game = 1'b1; move_valid = 1'b1; move_cell = 4'd2;
    @(negedge clk_10000Hz);
    new_game = 1'b0; move_valid = 1'b0;
    chk("s5_ack", 9'(ack_cnt - a0), 9'd0);
    chk("s5_rej", 9'(rej_cnt - r0), 9'd0);
    chk_idle("s5");
    // move_valid held into the CHECK cycle
    a0 = ack_cnt; r0 = rej_cnt;
    move_cell = 4'd4; move_valid = 1'b1;
    @(negedge clk_10000Hz);
    move_cell = 4'd5;
    @(negedge clk_10000Hz);
    move_valid = 1'b0;
    chk("s5b_ack", 9'(ack_cnt - a0), 9'd1);
    chk("s5b_rej", 9'(rej_cnt - r0), 9'd1);
    chk("s5b_board_o", board_o, 9'h010);
    chk("s5b_board_x", board_x, 9'h000);
    @(negedge clk_10000Hz);
    restart_game();
    // full board with no line
    move(0); move(1); move(2); move(4); move(3); move(5); move(7); move(6); move(8);
    chk("s3_gameend", 9'(gameend), 9'h3);
    chk("s3_win_mask", win_mask, 9'h000);
    chk("s3_board_o", board_o, 9'h18D);
    chk("s3_board_x", board_x, 9'h072);
    restart_game();
    // reset lands in the CHECK cycle of a winning move
    move(0); move(3); move(1); move(4);
    move_cell = 4'd2; move_valid = 1'b1;
    @(negedge clk_10000Hz);
    move_valid = 1'b0; reset = 1'b1;
    @(negedge clk_10000Hz);
    reset = 1'b0;
    chk_idle("s6");
    repeat (3) @(negedge clk_10000Hz);
    chk("s6_gameend_hold", 9'(gameend), 9'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ttt_game_ctrl.md
Name: ttt_game_ctrl

Overview:
Turn sequencer and referee for the two-player O/X game.
- Accepts cell-select moves, keeps the two 3x3 occupancy boards and detects win or draw.
- Produces the whosTurn and gameend status consumed by the dot-matrix display driver, plus board bitmaps for the cell LEDs.
- Sits between the debounced keypad/button front end and the display blocks, all in the clk_10000Hz domain.

Parameters:
FIRST_PLAYER, 1'b0, player who moves first after reset/restart (0: O, 1: X)
AUTO_RESTART_TICKS, 30000, cycles to hold the result in DONE before automatic restart; 0 disables auto restart
CNT_W, 15, width of the DONE hold counter; must satisfy 2^CNT_W > AUTO_RESTART_TICKS

Ports:
clk_10000Hz  input  1  system clock, 10 kHz
reset  input  1  synchronous, active-high reset
new_game  input  1  single-cycle pulse: restart game
move_valid  input  1  single-cycle pulse: move_cell is a move request for current player
move_cell  input  4  cell index = row*3+col, legal 0..8
whosTurn  output  1  player to move (0: O, 1: X), registered
gameend  output  2  00 playing, 01 O won, 10 X won, 11 draw; registered
board_o  output  9  bit i set = cell i holds O
board_x  output  9  bit i set = cell i holds X
win_mask  output  9  cells of all completed lines of the winner; 0 unless gameend is 01/10
move_ack  output  1  one-cycle pulse: previous-cycle move accepted
move_rej  output  1  one-cycle pulse: previous-cycle move rejected

Behaviour:
- Single clock domain. All outputs are registered and update only on posedge clk_10000Hz.
- Reset (reset=1 at a clock edge), at the next edge and regardless of state:
  - board_o = board_x = 0, win_mask = 0, gameend = 00, whosTurn = FIRST_PLAYER.
  - move_ack = move_rej = 0, move count = 0, hold counter = 0, state = PLAY.
- Restart = same clear as reset. Trigger: new_game=1, or the auto-restart timeout in DONE. Priority: reset > new_game > move_valid. A move in the same cycle as new_game is dropped with no ack and no rej.
- FSM states: PLAY, CHECK, DONE.
- PLAY, move_valid=1:
  - Legal move: move_cell<=8 and the cell is empty in both boards. Next edge sets bit move_cell in board_o (whosTurn=0) or board_x (whosTurn=1), increments the 4-bit move count, pulses move_ack=1 and goes to CHECK.
  - Illegal move: move_cell>=9 or cell occupied. Next edge pulses move_rej=1; state and boards are unchanged.
- CHECK (exactly one cycle):
  - Evaluate the mover's board (mover = whosTurn, not yet toggled) against 8 lines: {0,1,2} {3,4,5} {6,7,8} {0,3,6} {1,4,7} {2,5,8} {0,4,8} {2,4,6}.
  - Any line complete: gameend = 01 if mover is O, 10 if X; win_mask = OR of all complete lines; go to DONE. whosTurn is held.
  - Else if move count = 9: gameend = 11 (draw), win_mask = 0, go to DONE.
  - Else: toggle whosTurn and return to PLAY.
  - move_valid during CHECK gives move_rej next edge.
- Latency: gameend/whosTurn reflect a move 2 edges after the move_valid edge. The next move can be accepted on the edge after that.
- DONE:
  - Boards, gameend and win_mask are frozen. move_valid gives move_rej next edge.
  - If AUTO_RESTART_TICKS != 0, the hold counter increments each cycle from 0. At value AUTO_RESTART_TICKS-1 the next edge performs a restart.
  - If AUTO_RESTART_TICKS = 0, the block stays in DONE until new_game or reset.
- move_ack and move_rej are never both 1 and are 0 in every cycle not listed above.
- A win on the 9th move reports a win, not a draw.

Test Plan:
1. O-row win: reset, then moves 0(O), 3(X), 1(O), 4(X), 2(O), one move per 3 cycles. Required: five move_ack pulses; 2 edges after last move gameend=01, win_mask=9'h007, board_o=9'h007, board_x=9'h018, whosTurn=0.
2. Illegal moves: O plays 4, then X plays 4, then X plays 9. Required: move_rej pulses twice, board_x stays 0, whosTurn stays 1, gameend=00.
3. Draw: sequence O:0, X:1, O:2, X:4, O:3, X:5, O:7, X:6, O:8. Required: gameend=11, win_mask=0, board_o=9'h18D, board_x=9'h072.
4. Auto restart, AUTO_RESTART_TICKS=5: reach the O win from scenario 1. Required: DONE state held exactly 5 cycles, then all outputs at reset values with whosTurn=FIRST_PLAYER. A move_valid during DONE gives only move_rej.
5. Priority: new_game and move_valid asserted in the same cycle mid-game. Required: boards cleared, no ack/rej. Separately, move_valid in the CHECK cycle gives move_rej and board unchanged.
6. Reset mid-operation: assert reset in the CHECK cycle of a winning move. Required: next edge all outputs at reset values, gameend stays 00.
